wb_select_pipe: RTL and testbench
=================================

# wb_select_pipe

Parametrised write-back data selector for the multicycle datapath: picks one of `NSRC` result buses (ALU, load/store, HI, LO, shifter, set-less-than, ...) by a source code and delivers it through a registered valid/ready stage to the register-file write port. It replaces the purely combinational write-data mux:
- every select code has a defined result;
- the output is registered;
- an illegal select is flagged instead of silently holding the previous value.

## Interface
Parameters:
- `WIDTH`, 32, width of each source bus and of the output.
- `NSRC`, 6, number of source buses (2..16).
- `SELW`, `$clog2(NSRC)` (min 1), width of the select code.

Ports:
- `clk` in 1, single clock, all state updates on rising edge.
- `reset` in 1, synchronous, active-high.
- `sel` in `SELW`, source code; `src_data[k*WIDTH +: WIDTH]` is source k.
- `src_data` in `NSRC*WIDTH`, flattened source buses.
- `in_valid` in 1, `sel`/`src_data` valid this cycle.
- `in_ready` out 1, stage can accept.
- `out_data` out `WIDTH`, selected, registered write data.
- `out_valid` out 1, `out_data` valid.
- `out_ready` in 1, consumer (register-file write control) accepts.
- `sel_err` out 1, sticky: an accepted transfer carried `sel >= NSRC`.

## Operation
- Accept: `in_valid && in_ready` at a rising edge captures `src_data[sel]`.
- Illegal select: if `sel >= NSRC`, the captured word is all-zero and `sel_err` is set to 1. `sel_err` stays 1 until `reset`. Such a transfer still produces an `out_valid` beat.
- Transfer out: a beat completes when `out_valid && out_ready` at a rising edge.
- Ordering: in-order, no drops, no duplicates. Each accepted input yields exactly one output beat.
- Stability: while `out_valid && !out_ready`, `out_data` holds constant.
- Inputs are sampled only on accept. `sel`/`src_data` changes while `in_ready=0` have no effect.
- Simultaneous accept and drain in the same cycle: the new word replaces the drained one, and `out_valid` stays 1.
- Reset mid-operation: any held beats are discarded. All outputs return to their reset values on the next edge.
- Reset values: `out_valid=0`, `out_data=0`, `sel_err=0`, `in_ready=1`. Internal skid entry (when configured) is empty.

## Timing
- Latency: 1 cycle, accept at edge N gives `out_valid=1` from edge N.
- Throughput: 1 beat/cycle while `out_ready=1`.
- Without skid: `in_ready = !out_valid || out_ready` (combinational path from `out_ready`).
- With skid: `in_ready` is a register output (`!skid_full`), and a full pipeline holds 2 beats.
- Skid behaviour: when a beat is accepted while the output is stalled, it parks in the skid entry. The skid entry moves to the output on the next drain.

## Configuration
- `WB_SELECT_SKID_EN` defined: a second register stage (skid entry) is instantiated. `in_ready` has no combinational dependence on `out_ready`, and capacity is 2.
- Undefined: single output register, capacity 1, `in_ready` combinational as above.
- Functional results (data, order, `sel_err`) are identical in both builds. Only the `in_ready` timing and capacity differ.

## Structure
- Package `wb_select_pkg`: source-code localparams `SRC_ULA=0`, `SRC_LS=1`, `SRC_HI=2`, `SRC_LO=3`, `SRC_SHIFT=4`, `SRC_LT=5`, and `WB_NSRC_DEFAULT=6`. The control FSM and this block both import it.
- Sub-module `wb_skid_reg`: one WIDTH-wide valid/ready register slice. It is instantiated once without the macro and twice with it. The select logic stays in the top module.

## Test plan
- Reset: assert `reset` for 2 cycles. Expect `out_valid=0`, `out_data=0`, `sel_err=0`, `in_ready=1`.
- Each source: sources k = `32'h1000_0000+k`, drive `sel=0..5` with `out_ready=1`. Expect `out_data=32'h1000_0000..32'h1000_0005`, 1 cycle after each accept, with no gaps.
- Illegal select: accept `sel=6` with `src_data` nonzero. Expect one beat with `out_data=0` and `sel_err=1`. Then accept `sel=2` with HI=`32'hDEAD_BEEF`: expect `32'hDEAD_BEEF`, and `sel_err` stays 1.
- Backpressure: set `out_ready=0` for 4 cycles while `in_valid=1`.
  - Without skid: exactly 1 word accepted.
  - With skid: exactly 2 words accepted.
  - On release, expect the words in order, `out_data` stable while stalled, and no loss.
- Simultaneous: hold `out_valid=1`, `out_ready=1`, `in_valid=1` for 3 cycles. Expect a new word every cycle and `out_valid` continuously 1.
- Reset mid-stall: with 2 beats held (skid build), pulse `reset`. Next cycle expect `out_valid=0`, `in_ready=1`, `sel_err=0`, and no stale beat afterward.

Source files
------------

// File: rtl/wb_select_pkg.sv
// Shared write-back source codes for the multicycle datapath.
// Imported by the control FSM and by wb_select_pipe.
package wb_select_pkg;

    localparam int unsigned SRC_ULA         = 0;
    localparam int unsigned SRC_LS          = 1;
    localparam int unsigned SRC_HI          = 2;
    localparam int unsigned SRC_LO          = 3;
    localparam int unsigned SRC_SHIFT       = 4;
    localparam int unsigned SRC_LT          = 5;
    localparam int unsigned WB_NSRC_DEFAULT = 6;

    function automatic logic wb_sel_legal(input int unsigned sel, input int unsigned nsrc);
        return sel < nsrc;
    endfunction

endpackage

// File: rtl/wb_skid_reg.sv
// One WIDTH-wide valid/ready register slice; accepts whenever empty or draining.
// Data holds while stalled, so the consumer sees a stable word.
module wb_skid_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             out_ready_i
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;

    always_comb begin
        valid_d    = valid_q;
        data_d     = data_q;
        in_ready_o = !valid_q || out_ready_i;
        if (in_valid_i && in_ready_o) begin
            valid_d = 1'b1;
            data_d  = in_data_i;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

endmodule

// File: rtl/wb_select_pipe.sv
// Registered write-back source selector with sticky illegal-select flag.
// Define WB_SELECT_SKID_EN for a skid entry (registered in_ready, capacity 2).
module wb_select_pipe
    import wb_select_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NSRC  = WB_NSRC_DEFAULT,
    parameter int unsigned SELW  = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SELW-1:0]       sel,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sel_err
);

    logic             accept;
    logic             sel_ok;
    logic [WIDTH-1:0] sel_word;
    logic             sel_err_q, sel_err_d;

    logic             main_in_valid;
    logic [WIDTH-1:0] main_in_data;
    logic             main_in_ready;

    // Illegal codes match no source and therefore yield an all-zero word.
    always_comb begin
        sel_word = '0;
        for (int unsigned k = 0; k < NSRC; k++) begin
            if (32'(sel) == k) begin
                sel_word = src_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign sel_ok    = wb_sel_legal(32'(sel), NSRC);
    assign accept    = in_valid && in_ready;
    assign sel_err_d = sel_err_q || (accept && !sel_ok);

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err = sel_err_q;

`ifdef WB_SELECT_SKID_EN
    logic             skid_valid;
    logic             skid_in_ready;
    logic             skid_load;
    logic [WIDTH-1:0] skid_data;

    // A parked word always has priority into the output stage, so the
    // input is blocked (in_ready=0) whenever the skid entry is occupied.
    assign in_ready      = !skid_valid;
    assign skid_load     = accept && !main_in_ready && skid_in_ready;
    assign main_in_valid = skid_valid || accept;
    assign main_in_data  = skid_valid ? skid_data : sel_word;

    wb_skid_reg #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk        (clk),
        .reset      (reset),
        .in_valid_i (skid_load),
        .in_data_i  (sel_word),
        .in_ready_o (skid_in_ready),
        .out_valid_o(skid_valid),
        .out_data_o (skid_data),
        .out_ready_i(main_in_ready)
    );
`else
    assign in_ready      = main_in_ready;
    assign main_in_valid = in_valid;
    assign main_in_data  = sel_word;
`endif

    wb_skid_reg #(
        .WIDTH(WIDTH)
    ) u_main (
        .clk        (clk),
        .reset      (reset),
        .in_valid_i (main_in_valid),
        .in_data_i  (main_in_data),
        .in_ready_o (main_in_ready),
        .out_valid_o(out_valid),
        .out_data_o (out_data),
        .out_ready_i(out_ready)
    );

endmodule

// File: tb/tb_wb_select_pipe.sv
// Directed bench for wb_select_pipe; capacity expectations follow WB_SELECT_SKID_EN.
module tb_wb_select_pipe;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned NSRC  = 6;
    localparam int unsigned SELW  = 3;
`ifdef WB_SELECT_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic [SELW-1:0]       sel;
    logic [NSRC*WIDTH-1:0] src_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  sel_err;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_acc;
    logic [31:0] exp_q[$];

    wb_select_pipe #(
        .WIDTH(WIDTH),
        .NSRC (NSRC),
        .SELW (SELW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sel      (sel),
        .src_data (src_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sel_err  (sel_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_src(input int k, input logic [31:0] v);
        src_data[k*WIDTH +: WIDTH] = v;
    endtask

    initial begin
        reset     = 1'b1;
        sel       = '0;
        src_data  = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data,  0);
        check("rst_sel_err",   sel_err,   0);
        check("rst_in_ready",  in_ready,  1);

        // Each source in turn, back to back.
        for (int k = 0; k < 6; k++) set_src(k, 32'h1000_0000 + k);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            sel = SELW'(k);
            #1;
            check("src_in_ready", in_ready, 1);
            step();
            check("src_out_valid", out_valid, 1);
            check("src_out_data",  out_data,  32'h1000_0000 + k);
        end

        // Illegal select, then a legal one; flag must stay set.
        sel = 3'd6;
        step();
        check("ill_out_valid", out_valid, 1);
        check("ill_out_data",  out_data,  0);
        check("ill_sel_err",   sel_err,   1);
        set_src(2, 32'hDEAD_BEEF);
        sel = 3'd2;
        step();
        check("hi_out_data", out_data, 32'hDEAD_BEEF);
        check("hi_sel_err",  sel_err,  1);
        in_valid = 1'b0;
        step();
        check("idle_out_valid", out_valid, 0);

        // Backpressure: 4 stalled cycles with the input always offering.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel       = 3'd3;
        n_acc     = 0;
        for (int i = 0; i < 4; i++) begin
            set_src(3, 32'hB000_0000 + i);
            #1;
            if (in_ready) begin
                exp_q.push_back(32'hB000_0000 + i);
                n_acc++;
            end
            step();
            check("stall_valid", out_valid, 1);
            check("stall_data",  out_data,  32'hB000_0000);
        end
        check("stall_accepts", n_acc, CAP);
        check("stall_in_ready", in_ready, 0);

        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (out_valid) begin
                if (exp_q.size() > 0) check("drain_data", out_data, exp_q.pop_front());
                else                  check("extra_beat", out_valid, 0);
            end
            step();
        end
        check("drain_left",  exp_q.size(), 0);
        check("drain_valid", out_valid, 0);

        // Simultaneous accept and drain every cycle.
        in_valid = 1'b1;
        sel      = 3'd4;
        for (int i = 0; i < 4; i++) begin
            set_src(4, 32'hC000_0000 + i);
            step();
            check("sim_valid", out_valid, 1);
            check("sim_data",  out_data,  32'hC000_0000 + i);
        end
        in_valid = 1'b0;
        step();
        check("sim_idle", out_valid, 0);

        // Reset while stalled with beats held and the flag set.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel       = 3'd7;
        set_src(1, 32'h5555_AAAA);
        step();
        sel = 3'd1;
        step();
        check("pre_rst_sel_err", sel_err,   1);
        check("pre_rst_valid",   out_valid, 1);
        in_valid = 1'b0;
        reset    = 1'b1;
        step();
        check("mid_rst_valid",    out_valid, 0);
        check("mid_rst_in_ready", in_ready,  1);
        check("mid_rst_sel_err",  sel_err,   0);
        check("mid_rst_data",     out_data,  0);
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("post_rst_valid", out_valid, 0);
            check("post_rst_data",  out_data,  0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
